// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit:
//   state_t    - 4-bit FSM state encoding (also exported as p_state)
//   alu_op_t   - coarse ALU request from the FSM to the ALU decoder
//   OP_*       - instruction opcodes (Instr[31:26])
//   FN_*       - R-type function codes (Instr[5:0])
//   ALU_*      - ALUControl codes driven to the datapath ALU
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_control_if.sv
// ---------------------------------------------------------------------------
// mips_mc_control_if
// Bundle between the control unit and the datapath.
//   datapath -> control : opcode, funct (from IR), zero (ALU flag)
//   control -> datapath : write enables, PCEn, mux selects, ALUControl
// master = control unit, slave = datapath.
// ---------------------------------------------------------------------------
interface mips_mc_control_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       PCEn;
    logic       IorD;
    logic       ALUSrcA;
    logic       MemtoReg;
    logic       RegDst;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;

    modport master (
        input  opcode, funct, zero,
        output PCWrite, IRWrite, RegWrite, MemWrite, PCEn,
               IorD, ALUSrcA, MemtoReg, RegDst, ALUSrcB, PCSrc, ALUControl
    );

    modport slave (
        output opcode, funct, zero,
        input  PCWrite, IRWrite, RegWrite, MemWrite, PCEn,
               IorD, ALUSrcA, MemtoReg, RegDst, ALUSrcB, PCSrc, ALUControl
    );

endinterface

// File: rtl/mips_alu_decoder.sv
// ---------------------------------------------------------------------------
// mips_alu_decoder
// Combinational translation of the FSM's ALU request into ALUControl.
//   alu_op      in  2  add / sub / use funct
//   funct       in  6  Instr[5:0]
//   alu_control out 3  ALU function code
// Unrecognised funct values fall back to add.
// ---------------------------------------------------------------------------
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// ---------------------------------------------------------------------------
// mips_mc_control
// Moore FSM sequencing the shared multicycle MIPS datapath through fetch,
// decode and per-class execute/writeback steps, plus a retired-instruction
// counter.
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low reset
//   bus          master      opcode/funct/zero in; enables, selects out
//   p_state      out  4      current state encoding
//   instr_count  out  CNT_W  retired instructions (wraps)
// Outputs decode from the registered state only; PCEn also follows zero.
// While reset is low every write enable is held at 0.
// ---------------------------------------------------------------------------
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mips_mc_control_if.master bus,
    output logic [3:0]        p_state,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     next_state;
    alu_op_t    alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       iord;
    logic       alu_src_a;
    logic       mem_to_reg;
    logic       reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;

    // NOTE: state and counter use non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FETCH;
            instr_count <= '0;
        end else begin
            state <= next_state;
            // An instruction retires whenever control returns to FETCH.
            if (next_state == S_FETCH && state != S_FETCH)
                instr_count <= instr_count + CNT_ONE;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no
        // state/opcode path can leave one unassigned and infer a latch.
        next_state = S_FETCH;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALUOP_ADD;

        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b01;
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (bus.funct),
        .alu_control (alu_control)
    );

    // Enables are gated by reset itself so nothing writes while reset is
    // low, even in the instant before the state register clears.
    assign bus.PCWrite    = pc_write  & reset;
    assign bus.IRWrite    = ir_write  & reset;
    assign bus.RegWrite   = reg_write & reset;
    assign bus.MemWrite   = mem_write & reset;
    assign bus.PCEn       = (pc_write | (branch & bus.zero)) & reset;
    assign bus.IorD       = iord;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.RegDst     = reg_dst;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.PCSrc      = pc_src;
    assign bus.ALUControl = alu_control;
    assign p_state        = state;

endmodule
